// File: rtl/cache_bus_pkg.sv
// Shared types for the lv1<->lv2 bus arbiter: FSM state encoding and core id limits.
package cache_bus_pkg;

  localparam int NUM_CORES_MAX = 8;

  typedef logic [$clog2(NUM_CORES_MAX)-1:0] core_id_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PROC,
    ARB_PROC_SNP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter
  import cache_bus_pkg::*;
#(
  parameter int N      = 4,
  parameter int ID_WID = 2
) (
  input  logic [N-1:0]      req,
  input  logic [ID_WID-1:0] ptr,
  output logic [N-1:0]      gnt,
  output logic [ID_WID-1:0] id,
  output logic              vld
);

  always_comb begin
    gnt = '0;
    id  = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!vld && req[(int'(ptr) + i) % N]) begin
        vld = 1'b1;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        id  = ID_WID'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/lv1_lv2_bus_arbiter_mc.sv
// N-core lv1<->lv2 bus arbiter: round-robin proc grant, nested snoop write-back grant,
// invalidation ack collection, shared-line OR and a sticky hold-timeout monitor.
module lv1_lv2_bus_arbiter_mc
  import cache_bus_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int CORE_ID_WID = 2,
  parameter int MAX_HOLD    = 255,
  parameter int HOLD_WID    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_proc,
  output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_proc,
  input  logic [NUM_CORES-1:0]   bus_lv1_lv2_req_snoop,
  output logic [NUM_CORES-1:0]   bus_lv1_lv2_gnt_snoop,
  output logic [CORE_ID_WID-1:0] owner_id,
  output logic                   owner_vld,
  input  logic                   invalidate,
  input  logic [NUM_CORES-1:0]   invalidation_done,
  output logic                   all_invalidation_done,
  input  logic [NUM_CORES-1:0]   shared_local,
  output logic                   shared,
  output logic                   hold_timeout
);

  arb_state_e             state_reg, state_next;
  logic [NUM_CORES-1:0]   gnt_proc_reg, gnt_proc_next;
  logic [NUM_CORES-1:0]   gnt_snoop_reg, gnt_snoop_next;
  logic [CORE_ID_WID-1:0] owner_reg, owner_next;
  logic [CORE_ID_WID-1:0] snp_id_reg, snp_id_next;
  logic [CORE_ID_WID-1:0] rr_proc_ptr_reg, rr_proc_ptr_next;
  logic [CORE_ID_WID-1:0] rr_snp_ptr_reg, rr_snp_ptr_next;
  logic [NUM_CORES-1:0]   ack_vec_reg, ack_vec_next;
  logic                   all_inv_reg, all_inv_next;
  logic [HOLD_WID-1:0]    hold_cnt_reg, hold_cnt_next;
  logic                   timeout_reg, timeout_next;
  logic                   owner_keep;

  logic [NUM_CORES-1:0]   pw_gnt, sw_gnt;
  logic [CORE_ID_WID-1:0] pw_id, sw_id;
  logic                   pw_vld, sw_vld;

  function automatic logic [CORE_ID_WID-1:0] next_id(input logic [CORE_ID_WID-1:0] cur);
    return (cur == CORE_ID_WID'(NUM_CORES - 1)) ? '0 : cur + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_CORES), .ID_WID(CORE_ID_WID)) u_proc_arb (
    .req (bus_lv1_lv2_req_proc),
    .ptr (rr_proc_ptr_reg),
    .gnt (pw_gnt),
    .id  (pw_id),
    .vld (pw_vld)
  );

  // The owner can never be granted a snoop against its own transaction.
  rr_arbiter #(.N(NUM_CORES), .ID_WID(CORE_ID_WID)) u_snoop_arb (
    .req (bus_lv1_lv2_req_snoop & ~gnt_proc_reg),
    .ptr (rr_snp_ptr_reg),
    .gnt (sw_gnt),
    .id  (sw_id),
    .vld (sw_vld)
  );

  always_comb begin
    state_next       = state_reg;
    gnt_proc_next    = gnt_proc_reg;
    gnt_snoop_next   = gnt_snoop_reg;
    owner_next       = owner_reg;
    snp_id_next      = snp_id_reg;
    rr_proc_ptr_next = rr_proc_ptr_reg;
    rr_snp_ptr_next  = rr_snp_ptr_reg;
    owner_keep       = (|gnt_proc_reg) && bus_lv1_lv2_req_proc[owner_reg];

    case (state_reg)
      ARB_IDLE: begin
        gnt_snoop_next = '0;
        if (pw_vld) begin
          state_next    = ARB_PROC;
          gnt_proc_next = pw_gnt;
          owner_next    = pw_id;
        end
      end
      ARB_PROC: begin
        if (!bus_lv1_lv2_req_proc[owner_reg]) begin
          state_next       = ARB_IDLE;
          gnt_proc_next    = '0;
          rr_proc_ptr_next = next_id(owner_reg);
        end else if (sw_vld) begin
          state_next     = ARB_PROC_SNP;
          gnt_snoop_next = sw_gnt;
          snp_id_next    = sw_id;
        end
      end
      ARB_PROC_SNP: begin
        // Owner may leave mid-snoop; proc re-arbitration waits for the snoop to finish.
        if ((|gnt_proc_reg) && !bus_lv1_lv2_req_proc[owner_reg]) begin
          gnt_proc_next    = '0;
          rr_proc_ptr_next = next_id(owner_reg);
        end
        if (!bus_lv1_lv2_req_snoop[snp_id_reg]) begin
          gnt_snoop_next  = '0;
          rr_snp_ptr_next = next_id(snp_id_reg);
          state_next      = owner_keep ? ARB_PROC : ARB_IDLE;
        end
      end
      default: begin
        state_next     = ARB_IDLE;
        gnt_proc_next  = '0;
        gnt_snoop_next = '0;
      end
    endcase
  end

  always_comb begin
    ack_vec_next = '0;
    if (invalidate && (|gnt_proc_reg) && (|gnt_proc_next))
      ack_vec_next = ack_vec_reg | invalidation_done | gnt_proc_reg;
    all_inv_next = invalidate && (|gnt_proc_next) && (&ack_vec_reg);
  end

  always_comb begin
    hold_cnt_next = '0;
    timeout_next  = timeout_reg;
    if (state_reg != ARB_IDLE) begin
      hold_cnt_next = (hold_cnt_reg == HOLD_WID'(MAX_HOLD)) ? hold_cnt_reg : hold_cnt_reg + 1'b1;
      if (hold_cnt_next == HOLD_WID'(MAX_HOLD))
        timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ARB_IDLE;
      gnt_proc_reg    <= '0;
      gnt_snoop_reg   <= '0;
      owner_reg       <= '0;
      snp_id_reg      <= '0;
      rr_proc_ptr_reg <= '0;
      rr_snp_ptr_reg  <= '0;
      ack_vec_reg     <= '0;
      all_inv_reg     <= 1'b0;
      hold_cnt_reg    <= '0;
      timeout_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      gnt_proc_reg    <= gnt_proc_next;
      gnt_snoop_reg   <= gnt_snoop_next;
      owner_reg       <= owner_next;
      snp_id_reg      <= snp_id_next;
      rr_proc_ptr_reg <= rr_proc_ptr_next;
      rr_snp_ptr_reg  <= rr_snp_ptr_next;
      ack_vec_reg     <= ack_vec_next;
      all_inv_reg     <= all_inv_next;
      hold_cnt_reg    <= hold_cnt_next;
      timeout_reg     <= timeout_next;
    end
  end

  assign bus_lv1_lv2_gnt_proc  = gnt_proc_reg;
  assign bus_lv1_lv2_gnt_snoop = gnt_snoop_reg;
  assign owner_id              = owner_reg;
  assign owner_vld             = |gnt_proc_reg;
  assign all_invalidation_done = all_inv_reg;
  assign shared                = |(shared_local & ~gnt_proc_reg);
  assign hold_timeout          = timeout_reg;

endmodule

// File: tb/tb_lv1_lv2_bus_arbiter_mc.sv
// Directed bench for lv1_lv2_bus_arbiter_mc with a queue of expected grants per edge.
module tb_lv1_lv2_bus_arbiter_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_proc, gnt_proc, req_snoop, gnt_snoop;
  logic [1:0] owner_id;
  logic       owner_vld;
  logic       invalidate;
  logic [3:0] invalidation_done;
  logic       all_invalidation_done;
  logic [3:0] shared_local;
  logic       shared;
  logic       hold_timeout;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [3:0] gp;
    logic [3:0] gs;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  lv1_lv2_bus_arbiter_mc #(.NUM_CORES(4), .CORE_ID_WID(2), .MAX_HOLD(255), .HOLD_WID(8)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .bus_lv1_lv2_req_proc  (req_proc),
    .bus_lv1_lv2_gnt_proc  (gnt_proc),
    .bus_lv1_lv2_req_snoop (req_snoop),
    .bus_lv1_lv2_gnt_snoop (gnt_snoop),
    .owner_id              (owner_id),
    .owner_vld             (owner_vld),
    .invalidate            (invalidate),
    .invalidation_done     (invalidation_done),
    .all_invalidation_done (all_invalidation_done),
    .shared_local          (shared_local),
    .shared                (shared),
    .hold_timeout          (hold_timeout)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh2id(input logic [3:0] v);
    logic [1:0] r = '0;
    for (int i = 0; i < 4; i++)
      if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Drive one cycle of requests, queue the grants expected after the edge, then compare.
  task automatic step(input string tag, input logic [3:0] rp, input logic [3:0] rs,
                      input logic [3:0] egp, input logic [3:0] egs);
    exp_t e;
    req_proc  = rp;
    req_snoop = rs;
    sb.push_back('{gp: egp, gs: egs});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".gnt_proc"}, 32'(gnt_proc), 32'(e.gp));
    chk({tag, ".gnt_snoop"}, 32'(gnt_snoop), 32'(e.gs));
    chk({tag, ".owner_vld"}, 32'(owner_vld), 32'(|e.gp));
    if (e.gp != 4'b0000)
      chk({tag, ".owner_id"}, 32'(owner_id), 32'(oh2id(e.gp)));
    $display("[TB] %s rp=%b rs=%b gp=%b gs=%b", tag, rp, rs, gnt_proc, gnt_snoop);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_proc = '0; req_snoop = '0;
    invalidate = 1'b0; invalidation_done = '0; shared_local = '0;

    // Reset state
    step("rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("rst.owner_id", 32'(owner_id), 32'd0);
    chk("rst.all_inv", 32'(all_invalidation_done), 32'd0);
    chk("rst.timeout", 32'(hold_timeout), 32'd0);
    rst_n = 1'b1;

    // 1: lowest requester from pointer 0, then re-grant after release
    step("t1", 4'b0110, 4'b0000, 4'b0010, 4'b0000);
    step("t1", 4'b0110, 4'b0000, 4'b0010, 4'b0000);
    step("t1", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    step("t1", 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step("t1", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 2: fresh pointer, all cores request, 3-cycle holds separated by an idle bubble
    rst_n = 1'b0;
    step("t2rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      step("t2", 4'b1111, 4'b0000, oh, 4'b0000);
      step("t2", 4'b1111, 4'b0000, oh, 4'b0000);
      step("t2", 4'b1111, 4'b0000, oh, 4'b0000);
      step("t2", 4'b1111 & ~oh, 4'b0000, 4'b0000, 4'b0000);
    end
    step("t2", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 3: owner 2 with a nested snoop; owner's own snoop request ignored
    step("t3", 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step("t3own", 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    step("t3", 4'b0100, 4'b0101, 4'b0100, 4'b0001);
    step("t3", 4'b0100, 4'b0001, 4'b0100, 4'b0001);
    step("t3", 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step("t3", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // 4: owner 0, invalidation acks from 3,1,2 then a partial set
    step("t4", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    invalidate = 1'b1;
    invalidation_done = 4'b1000;
    step("t4", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("t4.ack3", 32'(all_invalidation_done), 32'd0);
    invalidation_done = 4'b0010;
    step("t4", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("t4.ack1", 32'(all_invalidation_done), 32'd0);
    invalidation_done = 4'b0100;
    step("t4", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("t4.ack2_same", 32'(all_invalidation_done), 32'd0);
    invalidation_done = 4'b0000;
    step("t4", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("t4.all_done", 32'(all_invalidation_done), 32'd1);
    invalidate = 1'b0;
    step("t4", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("t4.clear", 32'(all_invalidation_done), 32'd0);
    invalidate = 1'b1;
    invalidation_done = 4'b1000;
    step("t4p", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    invalidation_done = 4'b0010;
    step("t4p", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    invalidation_done = 4'b0000;
    step("t4p", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("t4.partial_a", 32'(all_invalidation_done), 32'd0);
    step("t4p", 4'b0001, 4'b0000, 4'b0001, 4'b0000);
    chk("t4.partial_b", 32'(all_invalidation_done), 32'd0);
    invalidate = 1'b0;
    shared_local = 4'b0001;
    #1 chk("t4.shared_owner_only", 32'(shared), 32'd0);
    shared_local = 4'b0101;
    #1 chk("t4.shared_other", 32'(shared), 32'd1);
    step("t4", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    shared_local = 4'b0001;
    #1 chk("t4.shared_no_owner", 32'(shared), 32'd1);
    shared_local = 4'b0000;

    // 5: long hold on core 1, timeout is sticky
    step("t5", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    for (int k = 0; k < 254; k++)
      step("t5", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    chk("t5.before_max", 32'(hold_timeout), 32'd0);
    step("t5", 4'b0010, 4'b0000, 4'b0010, 4'b0000);
    chk("t5.at_max", 32'(hold_timeout), 32'd1);
    step("t5", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("t5", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step("t5", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    chk("t5.sticky", 32'(hold_timeout), 32'd1);

    // 6: reset in the middle of a nested snoop; pointer returns to core 0
    step("t6", 4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step("t6", 4'b0100, 4'b0010, 4'b0100, 4'b0010);
    rst_n = 1'b0;
    step("t6rst", 4'b0100, 4'b0010, 4'b0000, 4'b0000);
    chk("t6.timeout_cleared", 32'(hold_timeout), 32'd0);
    rst_n = 1'b1;
    step("t6", 4'b1111, 4'b0000, 4'b0001, 4'b0000);

    // 7: owner drops during snoop; no new proc grant until the snoop ends
    step("t7", 4'b0001, 4'b0100, 4'b0001, 4'b0100);
    step("t7", 4'b1110, 4'b0100, 4'b0000, 4'b0100);
    step("t7", 4'b1110, 4'b0100, 4'b0000, 4'b0100);
    step("t7", 4'b1110, 4'b0000, 4'b0000, 4'b0000);
    step("t7", 4'b1110, 4'b0000, 4'b0010, 4'b0000);
    step("t7", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
